axi_rd_responder: RTL and testbench



---
 rtl/axi_rd_responder.sv | 185 ++++++++++++++++++
 tb/tb_axi_rd_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_responder.sv
// rtl/axi_rd_responder.sv - AXI read burst responder in front of a single-port synchronous SRAM
// Optional feature: define RD_ERR_CNT_EN to add ERR_CNT, a saturating count of bursts
// that returned at least one non-OKAY beat.
module axi_rd_responder #(
  parameter int                   IDS_BITS      = 8,
  parameter int                   ADDR_BITS     = 32,
  parameter int                   DATA_BITS     = 32,
  parameter int                   MEM_ADDR_BITS = 14,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR     = 32'h0001_0000
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [IDS_BITS-1:0]      ARID_S,
  input  logic [ADDR_BITS-1:0]     ARADDR_S,
  input  logic [3:0]               ARLEN_S,
  input  logic [2:0]               ARSIZE_S,
  input  logic [1:0]               ARBURST_S,
  input  logic                     ARVALID_S,
  output logic                     ARREADY_S,
  output logic [IDS_BITS-1:0]      RID_S,
  output logic [DATA_BITS-1:0]     RDATA_S,
  output logic [1:0]               RRESP_S,
  output logic                     RLAST_S,
  output logic                     RVALID_S,
  input  logic                     RREADY_S,
  output logic                     MEM_CS,
  output logic [MEM_ADDR_BITS-1:0] MEM_A,
  input  logic [DATA_BITS-1:0]     MEM_DO
`ifdef RD_ERR_CNT_EN
  ,
  output logic [7:0]               ERR_CNT
`endif
);

  localparam int WIN_LSB = MEM_ADDR_BITS + 2;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic [IDS_BITS-1:0]    id_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [ADDR_BITS-1:0]   addr_next;
  logic [ADDR_BITS-1:0]   addr_incr;
  logic [ADDR_BITS-1:0]   wrap_mask;
  logic [3:0]             len_q;
  logic [3:0]             cnt_q;
  logic [1:0]             burst_q;
  logic                   slverr_q;
  logic                   err_seen_q;
  logic                   ar_slverr;
  logic                   wrap_len_ok;
  logic                   beat_decerr;
  logic [1:0]             beat_resp;
  logic                   beat_ok;
  logic                   last_beat;
  logic                   ar_fire;
  logic                   r_fire;

  // Burst-level error: illegal size, reserved burst type, or a WRAP length that is not 2/4/8/16 beats
  assign wrap_len_ok = (ARLEN_S == 4'd1) || (ARLEN_S == 4'd3) ||
                       (ARLEN_S == 4'd7) || (ARLEN_S == 4'd15);
  assign ar_slverr   = (ARSIZE_S != 3'b010) || (ARBURST_S == BURST_RSVD) ||
                       ((ARBURST_S == BURST_WRAP) && !wrap_len_ok);

  // Beat outside the SRAM window decodes to nothing; a burst error outranks it
  assign beat_decerr = (addr_q[ADDR_BITS-1:WIN_LSB] != BASE_ADDR[ADDR_BITS-1:WIN_LSB]);
  assign beat_resp   = slverr_q ? RESP_SLVERR : (beat_decerr ? RESP_DECERR : RESP_OKAY);
  assign beat_ok     = (beat_resp == RESP_OKAY);
  assign last_beat   = (cnt_q == len_q);

  assign ar_fire = ARVALID_S & ARREADY_S;
  assign r_fire  = RVALID_S & RREADY_S;

  // WRAP keeps the upper bits of the (len+1)*4 byte block and lets only the offset roll over
  assign addr_incr = addr_q + ADDR_BITS'(4);
  assign wrap_mask = {{(ADDR_BITS-6){1'b0}}, len_q, 2'b11};

  // Next beat address from the latched burst type
  always_comb begin
    addr_next = addr_incr;
    case (burst_q)
      BURST_FIXED: addr_next = addr_q;
      BURST_WRAP:  addr_next = (addr_q & ~wrap_mask) | (addr_incr & wrap_mask);
      default:     addr_next = addr_incr;
    endcase
  end

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus handshake and SRAM strobe; each beat is one REQ cycle then one or more RESP cycles
  always_comb begin
    state_d   = state_q;
    ARREADY_S = 1'b0;
    RVALID_S  = 1'b0;
    MEM_CS    = 1'b0;
    case (state_q)
      S_IDLE: begin
        ARREADY_S = ~ARESET;
        if (ARVALID_S && !ARESET) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        MEM_CS  = beat_ok;
        state_d = S_RESP;
      end
      S_RESP: begin
        RVALID_S = 1'b1;
        if (RREADY_S) begin
          state_d = last_beat ? S_IDLE : S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the AR request, then step address and beat count on each accepted R beat
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      burst_q    <= '0;
      slverr_q   <= 1'b0;
      err_seen_q <= 1'b0;
    end else if (ar_fire) begin
      id_q       <= ARID_S;
      addr_q     <= ARADDR_S & ~ADDR_BITS'(3);
      len_q      <= ARLEN_S;
      cnt_q      <= '0;
      burst_q    <= ARBURST_S;
      slverr_q   <= ar_slverr;
      err_seen_q <= 1'b0;
    end else if (r_fire) begin
      if (!beat_ok) begin
        err_seen_q <= 1'b1;
      end
      if (!last_beat) begin
        addr_q <= addr_next;
        cnt_q  <= cnt_q + 4'd1;
      end
    end
  end

  // R channel and SRAM address; SRAM output is held while MEM_CS is low, so RDATA is stable under stall
  always_comb begin
    RID_S   = id_q;
    RLAST_S = RVALID_S & last_beat;
    RRESP_S = RVALID_S ? beat_resp : RESP_OKAY;
    RDATA_S = (RVALID_S && beat_ok) ? MEM_DO : '0;
    MEM_A   = MEM_CS ? addr_q[WIN_LSB-1:2] : '0;
  end

`ifdef RD_ERR_CNT_EN
  // Count bursts that carried any error beat, bumped on the final R handshake and saturating
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ERR_CNT <= 8'h00;
    end else if (r_fire && last_beat && (err_seen_q || !beat_ok) && (ERR_CNT != 8'hFF)) begin
      ERR_CNT <= ERR_CNT + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_responder.sv
// tb/tb_axi_rd_responder.sv - self-checking bench for axi_rd_responder (covers RD_ERR_CNT_EN when defined)
module tb_axi_rd_responder;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [31:0] WIN  = 32'h0001_0000;

  logic        ACLK;
  logic        ARESET;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S;
  logic        MEM_CS;
  logic [13:0] MEM_A;
  logic [31:0] MEM_DO;
`ifdef RD_ERR_CNT_EN
  logic [7:0]  ERR_CNT;
  int          exp_err;
`endif

  int n_total;
  int n_pass;

  axi_rd_responder dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .ARID_S    (ARID_S),
    .ARADDR_S  (ARADDR_S),
    .ARLEN_S   (ARLEN_S),
    .ARSIZE_S  (ARSIZE_S),
    .ARBURST_S (ARBURST_S),
    .ARVALID_S (ARVALID_S),
    .ARREADY_S (ARREADY_S),
    .RID_S     (RID_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RLAST_S   (RLAST_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .MEM_CS    (MEM_CS),
    .MEM_A     (MEM_A),
    .MEM_DO    (MEM_DO)
`ifdef RD_ERR_CNT_EN
    ,
    .ERR_CNT   (ERR_CNT)
`endif
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // SRAM contents are a fixed pattern of the word address
  function automatic logic [31:0] data_of(input logic [13:0] a);
    return {a, ~a[3:0], a ^ 14'h2A5A};
  endfunction

  // Synchronous SRAM: data appears the cycle after the strobe and is held otherwise
  initial MEM_DO = 32'h0;
  always @(posedge ACLK) begin
    if (MEM_CS) MEM_DO <= data_of(MEM_A);
  end

  // Reference byte address of beat k, straight from the burst-type definitions
  function automatic logic [31:0] beat_addr(input logic [31:0] start, input logic [3:0] len,
                                            input logic [1:0] b, input int k);
    logic [31:0] a;
    logic [31:0] blk;
    logic [31:0] base;
    a   = start & ~32'h3;
    blk = (32'(len) + 32'd1) * 32'd4;
    case (b)
      2'b00:   return a;
      2'b10: begin
        base = a - (a % blk);
        return base + (((a - base) + 32'(4 * k)) % blk);
      end
      default: return a + 32'(4 * k);
    endcase
  endfunction

  function automatic bit in_win(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + WIN);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one burst starting at an idle negedge and check every REQ/RESP cycle against the model
  task automatic do_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] b, input logic [15:0] smask);
    bit          slv;
    bit          any_err;
    logic [31:0] ba;
    logic [1:0]  er;
    logic [31:0] ed;
    slv = (size != 3'b010) || (b == 2'b11) ||
          ((b == 2'b10) && !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15));
    any_err = 1'b0;
    chk("arready_idle", 32'(ARREADY_S), 32'd1);
    ARID_S    = id;
    ARADDR_S  = addr;
    ARLEN_S   = len;
    ARSIZE_S  = size;
    ARBURST_S = b;
    ARVALID_S = 1'b1;
    for (int k = 0; k <= int'(len); k++) begin
      ba = beat_addr(addr, len, b, k);
      if (slv) er = 2'b10;
      else if (!in_win(ba)) er = 2'b11;
      else er = 2'b00;
      if (er != 2'b00) any_err = 1'b1;
      ed = (er == 2'b00) ? data_of(ba[15:2]) : 32'h0;
      @(negedge ACLK);
      ARVALID_S = 1'b0;
      chk("req_cs", 32'(MEM_CS), 32'(er == 2'b00));
      if (er == 2'b00) chk("req_mem_a", 32'(MEM_A), 32'(ba[15:2]));
      chk("req_rvalid", 32'(RVALID_S), 32'd0);
      chk("req_arready", 32'(ARREADY_S), 32'd0);
      RREADY_S = ~smask[k];
      @(negedge ACLK);
      chk("resp_rvalid", 32'(RVALID_S), 32'd1);
      chk("resp_rid", 32'(RID_S), 32'(id));
      chk("resp_rresp", 32'(RRESP_S), 32'(er));
      chk("resp_rlast", 32'(RLAST_S), 32'(k == int'(len)));
      chk("resp_rdata", RDATA_S, ed);
      chk("resp_cs_low", 32'(MEM_CS), 32'd0);
      if (smask[k]) begin
        @(negedge ACLK);
        chk("stall_rvalid", 32'(RVALID_S), 32'd1);
        chk("stall_rresp", 32'(RRESP_S), 32'(er));
        chk("stall_rlast", 32'(RLAST_S), 32'(k == int'(len)));
        chk("stall_rdata", RDATA_S, ed);
        RREADY_S = 1'b1;
      end
    end
    @(negedge ACLK);
    chk("post_rvalid", 32'(RVALID_S), 32'd0);
`ifdef RD_ERR_CNT_EN
    if (any_err && exp_err < 255) exp_err++;
    chk("err_cnt", 32'(ERR_CNT), 32'(exp_err));
`endif
  endtask

  initial begin
    logic [31:0] ra;
    logic [1:0]  rb;
    logic [2:0]  rs;
    int          r;
    n_total   = 0;
    n_pass    = 0;
    ARESET    = 1'b1;
    ARID_S    = 8'h0;
    ARADDR_S  = 32'h0;
    ARLEN_S   = 4'h0;
    ARSIZE_S  = 3'b010;
    ARBURST_S = 2'b01;
    ARVALID_S = 1'b0;
    RREADY_S  = 1'b1;
`ifdef RD_ERR_CNT_EN
    exp_err = 0;
`endif
    repeat (3) @(negedge ACLK);
    chk("rst_arready", 32'(ARREADY_S), 32'd0);
    chk("rst_rvalid", 32'(RVALID_S), 32'd0);
    chk("rst_rlast", 32'(RLAST_S), 32'd0);
    chk("rst_rresp", 32'(RRESP_S), 32'd0);
    chk("rst_rid", 32'(RID_S), 32'd0);
    chk("rst_mem_cs", 32'(MEM_CS), 32'd0);
    chk("rst_mem_a", 32'(MEM_A), 32'd0);
`ifdef RD_ERR_CNT_EN
    chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
`endif
    ARESET = 1'b0;
    @(negedge ACLK);

    // Directed cases
    do_burst(8'h15, 32'h0001_0010, 4'd0, 3'b010, 2'b01, 16'h0000);
    do_burst(8'h21, 32'h0001_0000, 4'd3, 3'b010, 2'b01, 16'h000A);
    do_burst(8'h33, 32'h0001_0008, 4'd3, 3'b010, 2'b10, 16'h0000);
    do_burst(8'h44, 32'h0001_0004, 4'd2, 3'b010, 2'b00, 16'h0002);
    do_burst(8'h55, 32'h0001_0020, 4'd1, 3'b001, 2'b01, 16'h0001);
    do_burst(8'h66, 32'h0002_0000, 4'd0, 3'b010, 2'b01, 16'h0000);
    do_burst(8'h77, BASE + WIN - 32'd4, 4'd1, 3'b010, 2'b01, 16'h0000);
    do_burst(8'h78, 32'h0001_0013, 4'd7, 3'b010, 2'b10, 16'h0000);
    do_burst(8'h79, 32'h0001_0040, 4'd2, 3'b010, 2'b10, 16'h0000);
    do_burst(8'h7A, 32'h0001_0040, 4'd0, 3'b010, 2'b11, 16'h0000);

    // Reset in the middle of a stalled burst
    chk("mid_arready", 32'(ARREADY_S), 32'd1);
    ARID_S    = 8'h9C;
    ARADDR_S  = 32'h0001_0100;
    ARLEN_S   = 4'd7;
    ARSIZE_S  = 3'b010;
    ARBURST_S = 2'b01;
    ARVALID_S = 1'b1;
    @(negedge ACLK);
    ARVALID_S = 1'b0;
    RREADY_S  = 1'b0;
    chk("mid_req_cs", 32'(MEM_CS), 32'd1);
    @(negedge ACLK);
    chk("mid_rvalid", 32'(RVALID_S), 32'd1);
    ARESET = 1'b1;
    @(negedge ACLK);
    chk("mid_rst_rvalid", 32'(RVALID_S), 32'd0);
    chk("mid_rst_cs", 32'(MEM_CS), 32'd0);
    chk("mid_rst_arready", 32'(ARREADY_S), 32'd0);
    ARESET   = 1'b0;
    RREADY_S = 1'b1;
`ifdef RD_ERR_CNT_EN
    exp_err = 0;
`endif
    @(negedge ACLK);
    chk("mid_after_rvalid", 32'(RVALID_S), 32'd0);
    chk("mid_after_cs", 32'(MEM_CS), 32'd0);
    do_burst(8'hA5, 32'h0001_0200, 4'd1, 3'b010, 2'b01, 16'h0000);

    // Randomized bursts against the reference model
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       ra = BASE + 32'($urandom_range(0, 32'hFFFF));
      else if (r == 7) ra = BASE + WIN - 32'd32 + 32'($urandom_range(0, 31));
      else if (r == 8) ra = BASE - 32'd32 + 32'($urandom_range(0, 31));
      else             ra = 32'($urandom_range(0, 32'h000F_FFFF));
      rb = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      do_burst(8'($urandom), ra, 4'($urandom_range(0, 15)), rs, rb, 16'($urandom));
    end

`ifdef RD_ERR_CNT_EN
    // Saturation of the error-burst counter, then an OKAY burst must leave it alone
    for (int i = 0; i < 260; i++) begin
      do_burst(8'($urandom), 32'h0001_0000, 4'd0, 3'b001, 2'b01, 16'h0000);
    end
    chk("err_cnt_sat", 32'(ERR_CNT), 32'h0000_00FF);
    do_burst(8'h01, 32'h0001_0000, 4'd1, 3'b010, 2'b01, 16'h0000);
    chk("err_cnt_hold", 32'(ERR_CNT), 32'h0000_00FF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
